// File: rtl/mesh_term_src.sv
// -----------------------------------------------------------------------------
// mesh_term_src
// Source stage for one mesh terminal. It accepts {dst, mode, payload} words
// from a host push strobe and rejects any word whose destination is not a
// reachable border terminal or broadcast. Accepted words are stamped with
// this terminal's {row, column} ID and queued in a FIFO. The head packet is
// presented to the router, which advances the queue with popin.
//
// Ports
//   clk           : clock, posedge
//   reset         : asynchronous active-low reset
//   push          : host write strobe (one word per cycle)
//   push_data     : {dst_row[3:0], dst_col[3:0], mode, payload}
//   pndng_i_in    : head packet valid toward router
//   data_out_i_in : registered head packet (0 when empty)
//   popin         : router consumed the head packet
//   count         : entries held
//   full          : count == fifo_depth
//   err           : one-cycle pulse after a push dropped for bad destination
//   drop_cnt      : saturating count of bad-destination drops
//   ovf_cnt       : saturating count of valid pushes lost to a full FIFO
// -----------------------------------------------------------------------------
module mesh_term_src #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 8,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int id_row     = 0,
    parameter int id_column  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [pckg_sz-9:0]            push_data,
    output logic                          pndng_i_in,
    output logic [pckg_sz-1:0]            data_out_i_in,
    input  logic                          popin,
    output logic [$clog2(fifo_depth):0]   count,
    output logic                          full,
    output logic                          err,
    output logic [7:0]                    drop_cnt,
    output logic [7:0]                    ovf_cnt
);

    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;

    localparam logic [3:0] LP_ID_ROW  = 4'(id_row);
    localparam logic [3:0] LP_ID_COL  = 4'(id_column);
    localparam logic [3:0] LP_ROW_MAX = 4'(ROWS);
    localparam logic [3:0] LP_COL_MAX = 4'(COLUMS);
    localparam logic [3:0] LP_ROW_OUT = 4'(ROWS + 1);
    localparam logic [3:0] LP_COL_OUT = 4'(COLUMS + 1);

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [pckg_sz-1:0] r_dout;
    logic               r_err;
    logic [7:0]         r_drop_cnt;
    logic [7:0]         r_ovf_cnt;

    logic [3:0]         w_dst_row;
    logic [3:0]         w_dst_col;
    logic               w_dst_ok;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_ovf;
    logic [pckg_sz-1:0] w_pkt;
    logic [AW-1:0]      w_rptr_nxt;
    logic [CW-1:0]      w_cnt_after_pop;
    logic [CW-1:0]      w_count_nxt;
    logic [pckg_sz-1:0] w_dout_nxt;

    assign w_dst_row = push_data[pckg_sz-9 -: 4];
    assign w_dst_col = push_data[pckg_sz-13 -: 4];
    assign w_pkt     = {LP_ID_ROW, LP_ID_COL, push_data};
    assign w_full    = (r_count == CW'(fifo_depth));

    always_comb begin
        w_dst_ok = 1'b0;
        if ((w_dst_row == 4'hF) && (w_dst_col == 4'hF))
            w_dst_ok = 1'b1;
        else if (((w_dst_row == 4'd0) || (w_dst_row == LP_ROW_OUT)) &&
                 (w_dst_col >= 4'd1) && (w_dst_col <= LP_COL_MAX))
            w_dst_ok = 1'b1;
        else if (((w_dst_col == 4'd0) || (w_dst_col == LP_COL_OUT)) &&
                 (w_dst_row >= 4'd1) && (w_dst_row <= LP_ROW_MAX))
            w_dst_ok = 1'b1;
        // Sending to ourselves is never legal.
        if ((w_dst_row == LP_ID_ROW) && (w_dst_col == LP_ID_COL))
            w_dst_ok = 1'b0;
    end

    // A pop frees the slot in the same cycle, so a full FIFO still accepts
    // a push when popin is present.
    assign w_do_pop  = popin && (r_count != '0);
    assign w_do_push = push && w_dst_ok && (!w_full || w_do_pop);
    assign w_ovf     = push && w_dst_ok && w_full && !w_do_pop;

    assign w_rptr_nxt      = w_do_pop ? (r_rptr + AW'(1)) : r_rptr;
    assign w_cnt_after_pop = r_count - CW'(w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next head: nothing left -> 0; if only the incoming word will remain it
    // bypasses the array; otherwise the surviving entry at the new read pointer.
    always_comb begin
        w_dout_nxt = '0;
        if (w_count_nxt == '0)
            w_dout_nxt = '0;
        else if (w_cnt_after_pop == '0)
            w_dout_nxt = w_pkt;
        else
            w_dout_nxt = r_mem[w_rptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr] <= w_pkt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_dout     <= '0;
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + AW'(1);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_dout  <= w_dout_nxt;
            r_err   <= push && !w_dst_ok;
            if (push && !w_dst_ok && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_ovf && (r_ovf_cnt != 8'hFF))
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign pndng_i_in    = (r_count != '0);
    assign data_out_i_in = r_dout;
    assign count         = r_count;
    assign full          = w_full;
    assign err           = r_err;
    assign drop_cnt      = r_drop_cnt;
    assign ovf_cnt       = r_ovf_cnt;

endmodule

// File: tb/tb_mesh_term_src.sv
// -----------------------------------------------------------------------------
// tb_mesh_term_src
// Randomized and directed stimulus for mesh_term_src, checked every cycle
// against a queue-based reference model of the terminal source stage.
// -----------------------------------------------------------------------------
module tb_mesh_term_src;

    localparam int PW    = 40;
    localparam int DEPTH = 8;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ID_R  = 0;
    localparam int ID_C  = 1;

    logic             clk;
    logic             reset;
    logic             push;
    logic [PW-9:0]    push_data;
    logic             pndng_i_in;
    logic [PW-1:0]    data_out_i_in;
    logic             popin;
    logic [3:0]       count;
    logic             full;
    logic             err;
    logic [7:0]       drop_cnt;
    logic [7:0]       ovf_cnt;

    mesh_term_src #(
        .pckg_sz   (PW),
        .fifo_depth(DEPTH),
        .ROWS      (ROWS),
        .COLUMS    (COLS),
        .id_row    (ID_R),
        .id_column (ID_C)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_data    (push_data),
        .pndng_i_in   (pndng_i_in),
        .data_out_i_in(data_out_i_in),
        .popin        (popin),
        .count        (count),
        .full         (full),
        .err          (err),
        .drop_cnt     (drop_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [PW-9:0] m_q[$];
    int            m_drop;
    int            m_ovf;
    bit            m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit dst_ok(input int r, input int c);
        if (r == ID_R && c == ID_C) return 1'b0;
        if (r == 15 && c == 15) return 1'b1;
        if ((r == 0 || r == ROWS + 1) && c >= 1 && c <= COLS) return 1'b1;
        if ((c == 0 || c == COLS + 1) && r >= 1 && r <= ROWS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [PW-9:0] mk(input int r, input int c, input bit mode, input int pl);
        logic [3:0]  r4;
        logic [3:0]  c4;
        logic [22:0] p23;
        r4  = 4'(r);
        c4  = 4'(c);
        p23 = 23'(pl);
        return {r4, c4, mode, p23};
    endfunction

    task automatic model_step(input bit p, input logic [PW-9:0] d, input bit pp);
        bit was_full;
        bit ok;
        int r;
        int c;
        r  = int'(d[31:28]);
        c  = int'(d[27:24]);
        ok = dst_ok(r, c);
        was_full = (m_q.size() == DEPTH);
        if (pp && m_q.size() > 0) void'(m_q.pop_front());
        m_err = p && !ok;
        if (p && !ok && m_drop < 255) m_drop++;
        if (p && ok) begin
            if (was_full && !pp) begin
                if (m_ovf < 255) m_ovf++;
            end else begin
                m_q.push_back(d);
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_drop = 0;
        m_ovf  = 0;
        m_err  = 1'b0;
    endtask

    task automatic compare_all();
        logic [PW-1:0] exp_dout;
        logic [7:0]    id8;
        id8      = {4'(ID_R), 4'(ID_C)};
        exp_dout = (m_q.size() > 0) ? {id8, m_q[0]} : '0;
        check("pndng", 64'(pndng_i_in), 64'(m_q.size() > 0));
        check("dout",  64'(data_out_i_in), 64'(exp_dout));
        check("count", 64'(count), 64'(m_q.size()));
        check("full",  64'(full), 64'(m_q.size() == DEPTH));
        check("err",   64'(err), 64'(m_err));
        check("drop",  64'(drop_cnt), 64'(m_drop));
        check("ovf",   64'(ovf_cnt), 64'(m_ovf));
    endtask

    task automatic cycle(input bit p, input logic [PW-9:0] d, input bit pp);
        @(negedge clk);
        push      = p;
        push_data = d;
        popin     = pp;
        @(posedge clk);
        model_step(p, d, pp);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        push  = 1'b0;
        popin = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [PW-9:0] rnd_word();
        int r;
        int c;
        if ($urandom_range(0, 9) == 0) begin
            r = 15;
            c = 15;
        end else begin
            r = int'($urandom_range(0, 5));
            c = int'($urandom_range(0, 5));
        end
        return mk(r, c, 1'($urandom_range(0, 1)), int'($urandom));
    endfunction

    initial begin
        push      = 1'b0;
        push_data = '0;
        popin     = 1'b0;
        reset     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // 1: single packet, exact header layout, then pop
        cycle(1'b1, mk(5, 2, 1'b0, 'h1234), 1'b0);
        check("t1_dout", 64'(data_out_i_in), 64'h0152001234);
        cycle(1'b0, '0, 1'b1);
        check("t1_pndng", 64'(pndng_i_in), 64'd0);

        // 2: interior and self destinations are dropped
        cycle(1'b1, mk(2, 2, 1'b0, 7), 1'b0);
        check("t2_err1", 64'(err), 64'd1);
        cycle(1'b1, mk(0, 1, 1'b0, 8), 1'b0);
        check("t2_err2", 64'(err), 64'd1);
        cycle(1'b0, '0, 1'b0);
        check("t2_drop", 64'(drop_cnt), 64'd2);

        // 3: fill, overflow, drain in order
        do_reset();
        for (int i = 1; i <= 9; i++) cycle(1'b1, mk(5, 1, 1'b0, i), 1'b0);
        check("t3_full", 64'(full), 64'd1);
        check("t3_ovf", 64'(ovf_cnt), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            check("t3_order", 64'(data_out_i_in[22:0]), 64'(i));
            cycle(1'b0, '0, 1'b1);
        end

        // 4: full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, mk(0, 3, 1'b1, i), 1'b0);
        cycle(1'b1, mk(15, 15, 1'b0, 'h55), 1'b1);
        check("t4_count", 64'(count), 64'd8);
        check("t4_ovf", 64'(ovf_cnt), 64'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

        // 5: asynchronous reset with popin held high
        for (int i = 1; i <= 5; i++) cycle(1'b1, mk(3, 5, 1'b0, i), 1'b0);
        cycle(1'b1, mk(9, 9, 1'b0, 0), 1'b0);
        @(negedge clk);
        push  = 1'b0;
        popin = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        popin = 1'b0;
        reset = 1'b1;
        cycle(1'b0, '0, 1'b0);

        // Random traffic, push-heavy then pop-heavy
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 9) < 7), rnd_word(), 1'($urandom_range(0, 9) < 3));
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 9) < 4), rnd_word(), 1'($urandom_range(0, 9) < 6));

        // 6: pop on empty, then drop counter saturation
        do_reset();
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 300; i++) cycle(1'b1, mk(1, 1, 1'b0, i), 1'b0);
        check("t6_sat", 64'(drop_cnt), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
